// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, reset program counter,
// fetch FSM state type and the queued fetch entry layout.
package cpu_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned ADDR_W = 16;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 16'h0010;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [WORD_W-1:0] word;
  } fetch_entry_t;

endpackage

// File: rtl/instr_queue.sv
// Instruction queue: FIFO of {pc, word} entries feeding the decoder.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   push, din           write entry at cycle end
//   pop                 drop head at cycle end (ignored when empty)
//   flush               empty the queue; overrides push and pop
//   head                current head entry
//   count, full, empty  occupancy
module instr_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               din,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t   store [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign do_push = push & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  assign head  = store[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        store[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        store[wr_ptr] <= din;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage. Owns the PC, issues pipelined reads to the
// instruction memory, captures returned words from d_bus and queues them
// for the decoder. Supports data-access priority (mem_busy), halt and
// jump redirection with squash of in-flight and queued words.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   mem_busy, halt             block new requests
//   jump, jump_addr            one-cycle redirect strobe and target
//   i_read, i_push, i_addr     memory control (i_read/i_push combinational)
//   d_bus                      shared bus, sampled in i_push cycles
//   instr, instr_pc            queue head word and its address
//   instr_valid, instr_ready   decoder handshake
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned       DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_busy,
  input  logic              halt,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              i_read,
  output logic              i_push,
  output logic [ADDR_W-1:0] i_addr,
  input  logic [WORD_W-1:0] d_bus,
  output logic [WORD_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned OW = CW + 1;

  fetch_state_t      state;
  fetch_state_t      next_state;
  logic [ADDR_W-1:0] pc;
  logic              req_v;
  logic [ADDR_W-1:0] req_pc;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              pop;
  logic [OW-1:0]     occupancy;
  logic              space;
  fetch_entry_t      q_din;
  fetch_entry_t      q_head;

  assign pop         = instr_valid & instr_ready;
  // Occupancy after this cycle counts the word already in flight, so a
  // request is only issued when its word is guaranteed a free slot.
  assign occupancy   = OW'(count) + OW'(req_v) - OW'(pop);
  assign space       = (occupancy < OW'(DEPTH));

  assign i_addr      = pc;
  assign instr_valid = ~empty;
  assign instr       = q_head.word;
  assign instr_pc    = q_head.pc;
  assign q_din       = '{pc: req_pc, word: d_bus};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    i_read     = 1'b0;
    unique case (state)
      BOOT: next_state = RUN;
      RUN:  i_read     = ~mem_busy & ~halt & ~jump & space;
      default: next_state = BOOT;
    endcase
    i_push = req_v & ~jump;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      req_v  <= 1'b0;
      req_pc <= '0;
    end else if (jump) begin
      pc    <= jump_addr;
      req_v <= 1'b0;
    end else begin
      req_v <= i_read;
      if (i_read) begin
        pc     <= pc + 1'b1;
        req_pc <= pc;
      end
    end
  end

  instr_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (i_push),
    .pop   (pop),
    .flush (jump),
    .din   (q_din),
    .head  (q_head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(i_push && full && !pop));
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam int unsigned DEPTH  = 2;
  localparam logic [15:0] RST_PC = 16'h0010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_busy;
  logic        halt;
  logic        jump;
  logic [15:0] jump_addr;
  logic        i_read;
  logic        i_push;
  logic [15:0] i_addr;
  logic [15:0] d_bus;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_PC (RST_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_busy    (mem_busy),
    .halt        (halt),
    .jump        (jump),
    .jump_addr   (jump_addr),
    .i_read      (i_read),
    .i_push      (i_push),
    .i_addr      (i_addr),
    .d_bus       (d_bus),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  // Memory model: read latches a word at cycle end, push drives it next cycle.
  logic [15:0] mem [256];
  logic [15:0] rdata;
  always @(posedge clk) if (i_read) rdata <= mem[i_addr[7:0]];
  assign d_bus = i_push ? rdata : 16'h5A5A;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: ordered list of requested-but-unconsumed addresses.
  logic [15:0] exp_q[$];
  logic [15:0] consumed[$];
  logic [15:0] fetch_addr;
  bit          prev_read;
  int          since_rst;
  int          reads_seen;
  int          first_read;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; mem_busy = 1'b0; halt = 1'b0; jump = 1'b0;
    instr_ready = 1'b0; jump_addr = '0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    exp_q.delete(); consumed.delete();
    fetch_addr = RST_PC; prev_read = 1'b0; since_rst = 0;
    reads_seen = 0; first_read = -1;
    #1;
    chk("rst_i_read", i_read, 1'b0);
    chk("rst_i_push", i_push, 1'b0);
    chk("rst_i_addr", i_addr, RST_PC);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_instr_pc", instr_pc, 16'h0000);
    rst_n = 1'b1;
  endtask

  // One clock cycle with rst_n high: check outputs against the model, then advance.
  task automatic cycle();
    bit pop, er, ep, ev;
    logic [15:0] h;
    #1;
    pop = instr_valid && instr_ready;
    ep  = prev_read && !jump;
    er  = (since_rst > 0) && !mem_busy && !halt && !jump &&
          ((exp_q.size() - int'(pop)) < int'(DEPTH));
    ev  = (exp_q.size() - int'(prev_read)) > 0;
    chk("i_read", i_read, er);
    chk("i_push", i_push, ep);
    chk("instr_valid", instr_valid, ev);
    if (instr_valid && exp_q.size() > 0) begin
      h = exp_q[0];
      chk("instr_pc", instr_pc, h);
      chk("instr", instr, mem[h[7:0]]);
    end
    if (i_read) begin
      chk("i_addr", i_addr, fetch_addr);
      if (first_read < 0) first_read = since_rst;
      reads_seen++;
    end
    if (jump) begin
      exp_q.delete();
      fetch_addr = jump_addr;
      prev_read  = 1'b0;
    end else begin
      if (pop && exp_q.size() > 0) consumed.push_back(exp_q.pop_front());
      if (i_read) begin
        exp_q.push_back(fetch_addr);
        fetch_addr = fetch_addr + 16'd1;
      end
      prev_read = i_read;
    end
    since_rst++;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[16] = 16'hBF00;
    mem[17] = 16'hCFB0;

    // Basic timeline from reset
    do_reset(2);
    instr_ready = 1'b1;
    cycle();
    #1; chk("t1_read_c1", i_read, 1'b1); chk("t1_addr_c1", i_addr, 16'h0010);
    cycle();
    #1; chk("t1_push_c2", i_push, 1'b1);
    cycle();
    #1; chk("t1_valid_c3", instr_valid, 1'b1);
    chk("t1_instr_c3", instr, 16'hBF00); chk("t1_pc_c3", instr_pc, 16'h0010);
    cycle();
    #1; chk("t1_instr_c4", instr, 16'hCFB0); chk("t1_pc_c4", instr_pc, 16'h0011);
    cycle();

    // Decoder stalled: exactly DEPTH words fetched, then resume
    do_reset(1);
    repeat (8) cycle();
    chk("t2_reads", 16'(reads_seen), 16'(DEPTH));
    #1;
    chk("t2_valid", instr_valid, 1'b1);
    chk("t2_instr", instr, 16'hBF00);
    chk("t2_no_read", i_read, 1'b0);
    instr_ready = 1'b1;
    repeat (6) cycle();
    chk("t2_consumed", 16'(consumed.size()), 16'd6);
    for (int k = 0; k < consumed.size(); k++)
      chk("t2_seq", consumed[k], RST_PC + 16'(k));

    // Data side busy during cycles 1-3
    do_reset(1);
    instr_ready = 1'b1;
    cycle();
    mem_busy = 1'b1;
    repeat (3) cycle();
    mem_busy = 1'b0;
    #1; chk("t3_read_c4", i_read, 1'b1); chk("t3_addr_c4", i_addr, 16'h0010);
    repeat (7) cycle();
    chk("t3_first_read", 16'(first_read), 16'd4);
    for (int k = 0; k < consumed.size(); k++)
      chk("t3_seq", consumed[k], RST_PC + 16'(k));

    // Jump with full queue
    do_reset(1);
    repeat (6) cycle();
    jump = 1'b1; jump_addr = 16'h00AB; instr_ready = 1'b1;
    cycle();
    jump = 1'b0;
    #1;
    chk("t4_valid", instr_valid, 1'b0);
    chk("t4_read", i_read, 1'b1);
    chk("t4_addr", i_addr, 16'h00AB);
    consumed.delete();
    repeat (4) cycle();
    chk("t4_first_pc", (consumed.size() > 0) ? consumed[0] : 16'hFFFF, 16'h00AB);

    // Jump with push in flight and concurrent pop, to 0xFFFF (wrap)
    jump = 1'b1; jump_addr = 16'hFFFF;
    cycle();
    jump = 1'b0;
    consumed.delete();
    repeat (6) cycle();
    chk("t5_pc0", (consumed.size() > 1) ? consumed[0] : 16'h1234, 16'hFFFF);
    chk("t5_pc1", (consumed.size() > 1) ? consumed[1] : 16'h1234, 16'h0000);

    // Halt: in-flight push completes, queue drains, resume at current pc
    do_reset(1);
    instr_ready = 1'b1;
    repeat (3) cycle();
    halt = 1'b1;
    repeat (5) cycle();
    #1; chk("t8_drained", instr_valid, 1'b0);
    halt = 1'b0;
    #1; chk("t8_resume_read", i_read, 1'b1); chk("t8_resume_addr", i_addr, 16'h0012);
    cycle();

    // Mid-stream reset with full queue
    instr_ready = 1'b0;
    repeat (6) cycle();
    #1; chk("t6_full_valid", instr_valid, 1'b1);
    do_reset(1);
    instr_ready = 1'b1;
    #1; chk("t6_valid_c0", instr_valid, 1'b0); chk("t6_read_c0", i_read, 1'b0);
    cycle();
    #1; chk("t6_read_c1", i_read, 1'b1); chk("t6_addr_c1", i_addr, 16'h0010);
    cycle();

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      mem_busy    = ($urandom_range(0, 3) == 0);
      halt        = ($urandom_range(0, 7) == 0);
      instr_ready = ($urandom_range(0, 2) != 0);
      jump        = ($urandom_range(0, 24) == 0);
      jump_addr   = 16'($urandom);
      if ($urandom_range(0, 149) == 0) do_reset(1);
      else cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
